// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - edge-capturing interrupt arbiter with ExtIRQ/ExtIAck handshake and snooped enable/EOI stores
// Optional macro IRQ_ARBITER_RR_EN selects round-robin winner selection instead of fixed priority.
module irq_arbiter #(
  parameter int NSRC = 4,
  parameter int N = 64,
  parameter logic [N-1:0] EN_ADDR = 'h7F0,
  parameter logic [N-1:0] EOI_ADDR = 'h7F8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC-1:0]         irq_src,
  input  logic [N-1:0]            DM_addr,
  input  logic [N-1:0]            DM_writeData,
  input  logic                    DM_writeEnable,
  input  logic                    ExtIAck,
  output logic                    ExtIRQ,
  output logic [$clog2(NSRC)-1:0] irq_id,
  output logic                    irq_active,
  output logic [NSRC-1:0]         irq_pending
);

  localparam int IDW = $clog2(NSRC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } stateType;

  stateType         state;
  stateType         stateNext;
  logic [NSRC-1:0]  srcQ;
  logic [NSRC-1:0]  pending;
  logic [NSRC-1:0]  pendingNext;
  logic [NSRC-1:0]  enable;
  logic [NSRC-1:0]  elig;
  logic [NSRC-1:0]  edgeSet;
  logic [NSRC-1:0]  ackClr;
  logic [IDW-1:0]   irqId;
  logic [IDW-1:0]   winner;
  logic             grantTake;
  logic             ackTake;
  logic             enWrite;
  logic             eoiWrite;
  logic             unusedData;

  assign enWrite    = DM_writeEnable && (DM_addr == EN_ADDR);
  assign eoiWrite   = DM_writeEnable && (DM_addr == EOI_ADDR);
  assign unusedData = ^DM_writeData[N-1:NSRC];

  // Registered enable and pending: an enable store only affects the following cycle's arbitration.
  assign elig    = pending & enable;
  assign edgeSet = irq_src & ~srcQ;
  assign ackClr  = ackTake ? (NSRC'(1) << irqId) : '0;
  // Set is applied after clear so a fresh edge during the ack keeps the bit pending.
  assign pendingNext = (pending & ~ackClr) | edgeSet;

`ifdef IRQ_ARBITER_RR_EN
  logic [IDW-1:0] rrPtr;

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int o = NSRC - 1; o >= 0; o--) begin
      idx = (int'(rrPtr) + o) % NSRC;
      if (elig[idx[IDW-1:0]]) winner = idx[IDW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (ackTake) begin
      rrPtr <= (irqId == IDW'(NSRC - 1)) ? '0 : irqId + 1'b1;
    end
  end
`else
  always_comb begin
    logic [IDW-1:0] k;
    k      = '0;
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      k = IDW'(i);
      if (elig[k]) winner = k;
    end
  end
`endif

  always_comb begin
    stateNext = state;
    grantTake = 1'b0;
    ackTake   = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) begin
          grantTake = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (ExtIAck) begin
          ackTake   = 1'b1;
          stateNext = SVC;
        end
      end
      SVC: begin
        if (eoiWrite) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      srcQ    <= '0;
      pending <= '0;
      enable  <= '1;
      irqId   <= '0;
    end else begin
      state   <= stateNext;
      srcQ    <= irq_src;
      pending <= pendingNext;
      if (enWrite) enable <= DM_writeData[NSRC-1:0];
      if (grantTake) irqId <= winner;
    end
  end

  assign ExtIRQ      = (state == REQ);
  assign irq_active  = (state == SVC);
  assign irq_id      = irqId;
  assign irq_pending = pending;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - self-checking bench for irq_arbiter: vector table, corner sequences, random vs reference model
module tb_irq_arbiter;

  localparam logic [63:0] EN_A  = 64'h7F0;
  localparam logic [63:0] EOI_A = 64'h7F8;
  localparam logic [1:0]  NOP = 2'd0;
  localparam logic [1:0]  ENW = 2'd1;
  localparam logic [1:0]  EOI = 2'd2;

`ifdef IRQ_ARBITER_RR_EN
  localparam logic [1:0] FIRST  = 2'd3;
  localparam logic [1:0] SECOND = 2'd1;
  localparam logic [3:0] LEFT   = 4'b0010;
`else
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd3;
  localparam logic [3:0] LEFT   = 4'b1000;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_writeEnable;
  logic        ExtIAck;
  logic        ExtIRQ;
  logic [1:0]  irq_id;
  logic        irq_active;
  logic [3:0]  irq_pending;

  irq_arbiter dut (
    .clk(clk),
    .reset(reset),
    .irq_src(irq_src),
    .DM_addr(DM_addr),
    .DM_writeData(DM_writeData),
    .DM_writeEnable(DM_writeEnable),
    .ExtIAck(ExtIAck),
    .ExtIRQ(ExtIRQ),
    .irq_id(irq_id),
    .irq_active(irq_active),
    .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: phase 0 = waiting, 1 = request outstanding, 2 = being serviced.
  logic [3:0] mPending;
  logic [3:0] mEnable;
  logic [3:0] mPrevSrc;
  int         mPhase;
  int         mId;
  int         mPtr;

  function automatic int pick(input logic [3:0] e);
`ifdef IRQ_ARBITER_RR_EN
    for (int k = 0; k < 4; k++) if (e[(mPtr + k) % 4]) return (mPtr + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (e[k]) return k;
`endif
    return 0;
  endfunction

  task automatic modelReset();
    mPending = 4'b0;
    mEnable  = 4'b1111;
    mPrevSrc = 4'b0;
    mPhase   = 0;
    mId      = 0;
    mPtr     = 0;
  endtask

  task automatic modelStep(input logic [3:0] src, input logic we, input logic [63:0] addr,
                           input logic [63:0] data, input logic ack);
    logic [3:0] eligible;
    logic [3:0] rising;
    eligible = mPending & mEnable;
    rising   = src & ~mPrevSrc;
    if (mPhase == 0) begin
      if (eligible != 4'b0) begin
        mId    = pick(eligible);
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (ack) begin
        mPending[mId] = 1'b0;
        mPtr          = (mId + 1) % 4;
        mPhase        = 2;
      end
    end else begin
      if (we && addr == EOI_A) mPhase = 0;
    end
    mPending = mPending | rising;
    if (we && addr == EN_A) mEnable = data[3:0];
    mPrevSrc = src;
  endtask

  task automatic drive(input logic rst, input logic [3:0] src, input logic we,
                       input logic [63:0] addr, input logic [63:0] data, input logic ack);
    reset          = rst;
    irq_src        = src;
    DM_writeEnable = we;
    DM_addr        = addr;
    DM_writeData   = data;
    ExtIAck        = ack;
    if (rst) modelReset();
    else modelStep(src, we, addr, data, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic driveOp(input logic rst, input logic [3:0] src, input logic [1:0] op,
                         input logic [3:0] data, input logic ack);
    logic [63:0] addr;
    addr = (op == ENW) ? EN_A : (op == EOI) ? EOI_A : 64'h100;
    drive(rst, src, op != NOP, addr, {60'h0, data}, ack);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkAll(input string tag, input logic irq, input logic [1:0] id,
                        input logic act, input logic [3:0] pend);
    chk({tag, "_irq"}, 32'(ExtIRQ), 32'(irq));
    chk({tag, "_id"}, 32'(irq_id), 32'(id));
    chk({tag, "_active"}, 32'(irq_active), 32'(act));
    chk({tag, "_pending"}, 32'(irq_pending), 32'(pend));
  endtask

  typedef struct {
    logic [3:0] src;
    logic [1:0] op;
    logic [3:0] data;
    logic       ack;
    logic       expIrq;
    logic [1:0] expId;
    logic       expActive;
    logic [3:0] expPend;
  } vecT;

  vecT vecs[$];

  task automatic addVec(input logic [3:0] src, input logic [1:0] op, input logic [3:0] data,
                        input logic ack, input logic irq, input logic [1:0] id,
                        input logic act, input logic [3:0] pend);
    vecT v;
    v.src = src; v.op = op; v.data = data; v.ack = ack;
    v.expIrq = irq; v.expId = id; v.expActive = act; v.expPend = pend;
    vecs.push_back(v);
  endtask

  initial begin
    // single grant, ack, EOI
    addVec(4'b0100, NOP, 4'h0, 1'b0, 1'b0, 2'd0,   1'b0, 4'b0100);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b1, 2'd2,   1'b0, 4'b0100);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, 2'd2,   1'b1, 4'b0000);
    addVec(4'b0000, EOI, 4'h0, 1'b0, 1'b0, 2'd2,   1'b0, 4'b0000);
    // two simultaneous edges
    addVec(4'b1010, NOP, 4'h0, 1'b0, 1'b0, 2'd2,   1'b0, 4'b1010);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b1, FIRST,  1'b0, 4'b1010);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, FIRST,  1'b1, LEFT);
    addVec(4'b0000, EOI, 4'h0, 1'b0, 1'b0, FIRST,  1'b0, LEFT);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b1, SECOND, 1'b0, LEFT);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, SECOND, 1'b1, 4'b0000);
    addVec(4'b0000, EOI, 4'h0, 1'b0, 1'b0, SECOND, 1'b0, 4'b0000);
    // masked source accumulates, unmask takes effect a cycle later
    addVec(4'b0000, ENW, 4'h0, 1'b0, 1'b0, SECOND, 1'b0, 4'b0000);
    addVec(4'b0001, NOP, 4'h0, 1'b0, 1'b0, SECOND, 1'b0, 4'b0001);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b0, SECOND, 1'b0, 4'b0001);
    addVec(4'b0000, ENW, 4'h1, 1'b0, 1'b0, SECOND, 1'b0, 4'b0001);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b1, 2'd0,   1'b0, 4'b0001);
    // ignored events: EOI in REQ, disable in REQ, ack in SVC, ack in IDLE
    addVec(4'b0000, EOI, 4'h0, 1'b0, 1'b1, 2'd0,   1'b0, 4'b0001);
    addVec(4'b0000, ENW, 4'h0, 1'b0, 1'b1, 2'd0,   1'b0, 4'b0001);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, 2'd0,   1'b1, 4'b0000);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, 2'd0,   1'b1, 4'b0000);
    addVec(4'b0000, ENW, 4'hF, 1'b0, 1'b0, 2'd0,   1'b1, 4'b0000);
    addVec(4'b0000, EOI, 4'h0, 1'b0, 1'b0, 2'd0,   1'b0, 4'b0000);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, 2'd0,   1'b0, 4'b0000);
    // new edge on the granted source during the ack
    addVec(4'b0100, NOP, 4'h0, 1'b0, 1'b0, 2'd0,   1'b0, 4'b0100);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b1, 2'd2,   1'b0, 4'b0100);
    addVec(4'b0100, NOP, 4'h0, 1'b1, 1'b0, 2'd2,   1'b1, 4'b0100);
    addVec(4'b0000, EOI, 4'h0, 1'b0, 1'b0, 2'd2,   1'b0, 4'b0100);
    addVec(4'b0000, NOP, 4'h0, 1'b0, 1'b1, 2'd2,   1'b0, 4'b0100);
    addVec(4'b0000, NOP, 4'h0, 1'b1, 1'b0, 2'd2,   1'b1, 4'b0000);

    driveOp(1'b1, 4'h0, NOP, 4'h0, 1'b0);
    driveOp(1'b1, 4'h0, NOP, 4'h0, 1'b0);
    chkAll("reset", 1'b0, 2'd0, 1'b0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      driveOp(1'b0, vecs[i].src, vecs[i].op, vecs[i].data, vecs[i].ack);
      chkAll($sformatf("vec%0d", i), vecs[i].expIrq, vecs[i].expId, vecs[i].expActive, vecs[i].expPend);
    end

    // reset while servicing with two sources pending and everything masked
    driveOp(1'b0, 4'b1010, NOP, 4'h0, 1'b0);
    chkAll("svc_pend", 1'b0, 2'd2, 1'b1, 4'b1010);
    driveOp(1'b0, 4'b0000, ENW, 4'h0, 1'b0);
    chkAll("svc_mask", 1'b0, 2'd2, 1'b1, 4'b1010);
    driveOp(1'b1, 4'b1000, NOP, 4'h0, 1'b0);
    chkAll("svc_reset", 1'b0, 2'd0, 1'b0, 4'b0000);
    // source held high through reset is captured as an edge; enable is back to all ones
    driveOp(1'b0, 4'b1000, NOP, 4'h0, 1'b0);
    chkAll("rel_edge", 1'b0, 2'd0, 1'b0, 4'b1000);
    driveOp(1'b0, 4'b1000, NOP, 4'h0, 1'b0);
    chkAll("rel_grant", 1'b1, 2'd3, 1'b0, 4'b1000);
    driveOp(1'b1, 4'b1000, NOP, 4'h0, 1'b0);
    chkAll("req_reset", 1'b0, 2'd0, 1'b0, 4'b0000);
    driveOp(1'b0, 4'b0000, NOP, 4'h0, 1'b0);
    chkAll("req_rel", 1'b0, 2'd0, 1'b0, 4'b0000);

    // randomized traffic against the reference model
    driveOp(1'b1, 4'h0, NOP, 4'h0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  src;
      logic        we;
      logic [63:0] addr;
      logic [63:0] data;
      logic        ack;
      logic        rst;
      src  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : irq_src;
      we   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: addr = EN_A;
        1: addr = EOI_A;
        2: addr = 64'h7F4;
        default: addr = {$urandom, $urandom};
      endcase
      data = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) data[3:0] = 4'hF;
      ack  = ($urandom_range(0, 1) == 1);
      rst  = ($urandom_range(0, 99) == 0);
      drive(rst, src, we, addr, data, ack);
      chkAll($sformatf("rnd%0d", c), mPhase == 1, 2'(mId), mPhase == 2, mPending);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Sits between NSRC external interrupt sources and the single ExtIRQ/ExtIAck pair of processor_arm.
- Captures rising edges into pending bits and selects one enabled pending source. Drives ExtIRQ until the core acknowledges, then holds the grant until software signals end-of-interrupt.
- Enable and end-of-interrupt are programmed by snooping processor stores on the DM_addr/DM_writeData/DM_writeEnable bus. Stores still reach dmem unchanged; this block does not intercept them.

Parameters:
- NSRC, 4, number of interrupt sources; valid range 2..16.
- N, 64, data/address bus width; matches the processor.
- EN_ADDR, 64'h7F0, store address of the interrupt-enable register.
- EOI_ADDR, 64'h7F8, store address of the end-of-interrupt strobe.

Ports:
- clk  in  1  system clock; same net as CLOCK_50.
- reset  in  1  synchronous, active-high reset.
- irq_src  in  NSRC  interrupt source lines; a rising edge means a request.
- DM_addr  in  N  processor data-memory address (snooped).
- DM_writeData  in  N  processor store data (snooped).
- DM_writeEnable  in  1  processor store strobe (snooped).
- ExtIAck  in  1  interrupt acknowledge from processor_arm.
- ExtIRQ  out  1  interrupt request to processor_arm.
- irq_id  out  $clog2(NSRC)  index of the granted source.
- irq_active  out  1  high while a granted interrupt is being serviced.
- irq_pending  out  NSRC  current pending bits.

Behaviour:
- Reset: clocked and synchronous, active-high; reset is sampled on the rising edge of clk. Values after reset:
  - ExtIRQ=0, irq_id=0, irq_active=0, irq_pending=0.
  - Enable register = all ones.
  - Edge register src_q = 0, so a source already high at reset release is captured as an edge on the first cycle.
  - FSM goes to IDLE.
  - Reset mid-operation abandons any grant, including in REQ or SVC.
- Edge capture:
  - src_q <= irq_src every cycle.
  - pending[i] is set when irq_src[i] & ~src_q[i].
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - A repeat edge on a bit that is already pending is merged; there is no counting.
- Enable write: when DM_writeEnable && DM_addr==EN_ADDR, enable <= DM_writeData[NSRC-1:0]. Arbitration in that same cycle uses the old enable. Masked sources still accumulate pending bits.
- Eligible set: elig = pending & enable.
- FSM states IDLE, REQ, SVC:
  - IDLE: if elig != 0, latch the winner into irq_id, set ExtIRQ=1, go to REQ. Otherwise stay.
  - REQ: hold ExtIRQ=1 and irq_id stable. When ExtIAck=1 is sampled: ExtIRQ<=0, pending[irq_id]<=0 (unless a new edge arrives that same cycle), irq_active<=1, go to SVC. Clearing the source's enable while in REQ does not retract the request.
  - SVC: when DM_writeEnable && DM_addr==EOI_ADDR (data ignored): irq_active<=0, go to IDLE. irq_id keeps its value until the next grant.
- Ignored events:
  - ExtIAck in IDLE or SVC.
  - EOI store in IDLE or REQ.
  - An EN_ADDR store is honoured in every state.
- Latency:
  - Edge sampled at clock k → pending visible after k → ExtIRQ high after k+1.
  - EOI at clock m → IDLE after m. If elig != 0, ExtIRQ is high again after m+1.
  - Minimum spacing between grants: 3 cycles.
- Winner selection (default): fixed priority, lowest index first.
- No nesting: exactly one outstanding grant at a time.

Optional Feature:
- Macro: IRQ_ARBITER_RR_EN.
- Defined: round-robin selection. A pointer (reset 0) holds the search start; the winner is the first eligible index at or after the pointer, wrapping modulo NSRC. On each ExtIAck in REQ, pointer <= irq_id+1, wrapping to 0.
- Undefined: fixed priority, lowest index wins; no pointer register exists.

Test Plan:
- Reset, then pulse irq_src[2] → pending=4'b0100; ExtIRQ=1 two cycles after the edge with irq_id=2. ExtIAck → ExtIRQ=0, pending=0, irq_active=1. Store to 0x7F8 → irq_active=0.
- Edges on sources 1 and 3 in the same cycle → grant irq_id=1. After EOI, grant irq_id=3 within 2 cycles. With IRQ_ARBITER_RR_EN: with pointer=2, sources 1 and 3 edged → irq_id=3 first.
- Store 0x0 to 0x7F0, then pulse src 0 → pending[0]=1 and ExtIRQ stays 0. Store 0x1 to 0x7F0 → ExtIRQ=1 the cycle after the store, irq_id=0.
- Hold ExtIAck=1 in IDLE and store to 0x7F8 in REQ → no state change. ExtIRQ stays 1 until a real ack in REQ.
- New edge on the granted source in the same cycle as ExtIAck → pending bit stays 1; re-grant after EOI.
- Assert reset while in SVC with pending=4'b1010 → next cycle ExtIRQ=0, irq_active=0, pending=0, enable=4'b1111.
